// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: bundle of the sequencer's handshake and address signals.
//   master : conv_sequencer side (drives addresses, MAC controls, FIFO valid, finished pulse)
//   slave  : memory / MAC / FIFO side (drives inputs_loaded, K, fifo_in_tready)
// Signals:
//   inputs_loaded    memories hold a complete X/W/K/B set
//   K                kernel size, valid while inputs_loaded=1
//   X_read_addr      X memory read address (1-cycle synchronous read)
//   W_read_addr      W memory read address (1-cycle synchronous read)
//   mac_input_valid  MAC inputs carry a valid term
//   mac_init_acc     first term of a window: load B + product
//   fifo_in_tvalid   MAC output holds a finished result
//   fifo_in_tready   FIFO can accept
//   compute_finished one-cycle pulse after the last output is written
interface conv_sequencer_if #(
    parameter int unsigned K_BITS = 3,
    parameter int unsigned XA_W   = 6,
    parameter int unsigned WA_W   = 5
);
    logic              inputs_loaded;
    logic [K_BITS-1:0] K;
    logic [XA_W-1:0]   X_read_addr;
    logic [WA_W-1:0]   W_read_addr;
    logic              mac_input_valid;
    logic              mac_init_acc;
    logic              fifo_in_tvalid;
    logic              fifo_in_tready;
    logic              compute_finished;

    modport master (
        input  inputs_loaded, K, fifo_in_tready,
        output X_read_addr, W_read_addr, mac_input_valid, mac_init_acc,
               fifo_in_tvalid, compute_finished
    );

    modport slave (
        output inputs_loaded, K, fifo_in_tready,
        input  X_read_addr, W_read_addr, mac_input_valid, mac_init_acc,
               fifo_in_tvalid, compute_finished
    );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer: control sequencer for the 2D convolution datapath.
// Walks every valid output position of an R x C input with a Kq x Kq kernel in raster
// order, issuing X/W read addresses one term per cycle, driving the MAC's input_valid and
// init_acc, then handing each finished sum to the output FIFO under AXIS handshake.
// Ports:
//   clk    system clock, all state on rising edge
//   reset  asynchronous active-low reset
//   bus    conv_sequencer_if.master (see interface file for signal list)
module conv_sequencer #(
    parameter int unsigned INW     = 18,
    parameter int unsigned R       = 8,
    parameter int unsigned C       = 8,
    parameter int unsigned MAXK    = 5,
    parameter int unsigned MAC_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    conv_sequencer_if.master bus
);
    localparam int unsigned K_BITS = $clog2(MAXK + 1);
    localparam int unsigned XA_W   = $clog2(R * C);
    localparam int unsigned WA_W   = $clog2(MAXK * MAXK);
    localparam int unsigned RW     = $clog2(R + 1);
    localparam int unsigned CW     = $clog2(C + 1);
    localparam int unsigned DW     = $clog2(MAC_LAT + 2);
    // A data word narrower than the K field marks a mis-sized instance; it refuses every set.
    localparam bit          CFG_OK = (INW >= K_BITS);

    typedef enum logic [2:0] {
        StIdle, StIssue, StDrain, StWrite, StDone, StWaitClr
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [K_BITS-1:0] i_q, i_d;
    logic [K_BITS-1:0] j_q, j_d;
    logic [K_BITS-1:0] kq_q, kq_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [XA_W-1:0]   xa_q;
    logic [WA_W-1:0]   wa_q;
    logic              miv_q;
    logic              mia_q;

    logic              k_bad;
    logic              last_j, last_i, last_c, last_r;
    logic [XA_W-1:0]   xa_cur;
    logic [WA_W-1:0]   wa_cur;

    always_comb begin
        k_bad  = (bus.K == '0) || (32'(bus.K) > MAXK) || (32'(bus.K) > R) ||
                 (32'(bus.K) > C) || !CFG_OK;
        last_j = (32'(j_q) == 32'(kq_q) - 32'd1);
        last_i = (32'(i_q) == 32'(kq_q) - 32'd1);
        last_c = (32'(c_q) == C - 32'(kq_q));
        last_r = (32'(r_q) == R - 32'(kq_q));
        xa_cur = XA_W'((32'(r_q) + 32'(i_q)) * C + 32'(c_q) + 32'(j_q));
        wa_cur = WA_W'(32'(i_q) * 32'(kq_q) + 32'(j_q));
    end

    // Next-state and counter updates.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        kq_d    = kq_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.inputs_loaded) begin
                    r_d    = '0;
                    c_d    = '0;
                    i_d    = '0;
                    j_d    = '0;
                    dcnt_d = '0;
                    kq_d   = bus.K;
                    state_d = k_bad ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (last_j) begin
                    j_d = '0;
                    if (last_i) begin
                        i_d     = '0;
                        dcnt_d  = '0;
                        state_d = StDrain;
                    end else begin
                        i_d = i_q + K_BITS'(1);
                    end
                end else begin
                    j_d = j_q + K_BITS'(1);
                end
            end
            StDrain: begin
                // Covers the 1-cycle read plus the MAC pipeline.
                if (32'(dcnt_q) == MAC_LAT) begin
                    state_d = StWrite;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            StWrite: begin
                if (bus.fifo_in_tready) begin
                    if (last_c) begin
                        c_d = '0;
                        if (last_r) begin
                            state_d = StDone;
                        end else begin
                            r_d     = r_q + RW'(1);
                            state_d = StIssue;
                        end
                    end else begin
                        c_d     = c_q + CW'(1);
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StWaitClr;
            end
            StWaitClr: begin
                // A still-high inputs_loaded belongs to the set just finished.
                if (!bus.inputs_loaded) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            kq_q    <= '0;
            dcnt_q  <= '0;
            xa_q    <= '0;
            wa_q    <= '0;
            miv_q   <= 1'b0;
            mia_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kq_q    <= kq_d;
            dcnt_q  <= dcnt_d;
            if (state_q == StIssue) begin
                xa_q <= xa_cur;
                wa_q <= wa_cur;
            end
            // Data for an address issued now reaches the MAC one cycle later.
            miv_q <= (state_q == StIssue);
            mia_q <= (state_q == StIssue) && (i_q == '0) && (j_q == '0);
        end
    end

    // Addresses follow the counters during ISSUE and hold their last value elsewhere.
    always_comb begin
        bus.X_read_addr      = (state_q == StIssue) ? xa_cur : xa_q;
        bus.W_read_addr      = (state_q == StIssue) ? wa_cur : wa_q;
        bus.mac_input_valid  = miv_q;
        bus.mac_init_acc     = mia_q;
        bus.fifo_in_tvalid   = (state_q == StWrite);
        bus.compute_finished = (state_q == StDone);
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench for conv_sequencer with a term scoreboard.
// Expected (X addr, W addr, init_acc) terms are queued when a set is started and popped
// whenever the DUT presents mac_input_valid; FIFO transfers, finish pulses and write
// timing are checked against values derived from R, C, K and MAC_LAT.
module tb_conv_sequencer;
    localparam int unsigned INW     = 18;
    localparam int unsigned R       = 8;
    localparam int unsigned C       = 8;
    localparam int unsigned MAXK    = 5;
    localparam int unsigned MAC_LAT = 4;
    localparam int unsigned K_BITS  = $clog2(MAXK + 1);
    localparam int unsigned XA_W    = $clog2(R * C);
    localparam int unsigned WA_W    = $clog2(MAXK * MAXK);

    typedef struct packed {
        logic [31:0] xa;
        logic [31:0] wa;
        logic        init;
    } term_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_sequencer_if #(.K_BITS(K_BITS), .XA_W(XA_W), .WA_W(WA_W)) bus ();

    conv_sequencer #(
        .INW(INW), .R(R), .C(C), .MAXK(MAXK), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    term_t           exp_terms[$];
    int              write_cyc[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              kk = 0;
    int              terms_since = 0;
    int              writes = 0;
    int              finished = 0;
    logic            prev_tvalid = 1'b0;
    logic [XA_W-1:0] prev_xa = '0;
    logic [WA_W-1:0] prev_wa = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge and score what happened at the last rising edge.
    task automatic tick();
        term_t t;
        @(negedge clk);
        cyc++;
        if (bus.mac_input_valid === 1'b1) begin
            check("term_expected", 32'(exp_terms.size() > 0), 32'd1);
            if (exp_terms.size() > 0) begin
                t = exp_terms.pop_front();
                check("x_addr", 32'(prev_xa), t.xa);
                check("w_addr", 32'(prev_wa), t.wa);
                check("init_acc", 32'(bus.mac_init_acc), 32'(t.init));
            end
            terms_since++;
        end
        if (prev_tvalid === 1'b1 && bus.fifo_in_tready === 1'b1) begin
            check("terms_per_window", terms_since, kk);
            terms_since = 0;
            write_cyc.push_back(cyc);
            writes++;
        end
        if (bus.compute_finished === 1'b1) finished++;
        prev_tvalid = bus.fifo_in_tvalid;
        prev_xa     = bus.X_read_addr;
        prev_wa     = bus.W_read_addr;
    endtask

    task automatic start_set(input int k);
        term_t t;
        writes      = 0;
        finished    = 0;
        terms_since = 0;
        kk          = 0;
        write_cyc.delete();
        if (k >= 1 && k <= int'(MAXK) && k <= int'(R) && k <= int'(C)) begin
            kk = k * k;
            for (int r = 0; r <= int'(R) - k; r++)
                for (int c = 0; c <= int'(C) - k; c++)
                    for (int i = 0; i < k; i++)
                        for (int j = 0; j < k; j++) begin
                            t.xa   = 32'((r + i) * int'(C) + c + j);
                            t.wa   = 32'(i * k + j);
                            t.init = (i == 0) && (j == 0);
                            exp_terms.push_back(t);
                        end
        end
        bus.K             = K_BITS'(k);
        bus.inputs_loaded = 1'b1;
    endtask

    task automatic wait_finish(input int budget, input bit rand_ready, output int used);
        used = 0;
        while (finished == 0 && used < budget) begin
            if (rand_ready) bus.fifo_in_tready = 1'($urandom_range(0, 1));
            tick();
            used++;
        end
        check("finish_in_budget", 32'(finished != 0), 32'd1);
    endtask

    // Holds inputs_loaded high after the finish pulse, so a restart would show up as terms.
    task automatic end_set(input int exp_writes);
        repeat (6) tick();
        check("writes", writes, exp_writes);
        check("finished_pulses", finished, 1);
        check("terms_left", exp_terms.size(), 0);
        bus.inputs_loaded = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int used;
        int n;
        logic [XA_W-1:0] xa0;
        logic [WA_W-1:0] wa0;

        reset              = 1'b1;
        bus.inputs_loaded  = 1'b0;
        bus.K              = '0;
        bus.fifo_in_tready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_x_addr", 32'(bus.X_read_addr), 0);
        check("rst_w_addr", 32'(bus.W_read_addr), 0);
        check("rst_miv", 32'(bus.mac_input_valid), 0);
        check("rst_init", 32'(bus.mac_init_acc), 0);
        check("rst_tvalid", 32'(bus.fifo_in_tvalid), 0);
        check("rst_finished", 32'(bus.compute_finished), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // K=3 with tready high: addresses, 36 writes, fixed write spacing.
        bus.fifo_in_tready = 1'b1;
        start_set(3);
        wait_finish(2000, 1'b0, used);
        for (int w = 0; w < write_cyc.size(); w++)
            check("write_spacing", write_cyc[w] - write_cyc[0], (9 + int'(MAC_LAT) + 2) * w);
        end_set(36);

        // K=3 with a 20-cycle FIFO stall on the first result.
        bus.fifo_in_tready = 1'b0;
        start_set(3);
        n = 0;
        while (bus.fifo_in_tvalid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("tvalid_seen", 32'(bus.fifo_in_tvalid), 1);
        xa0 = bus.X_read_addr;
        wa0 = bus.W_read_addr;
        repeat (20) begin
            tick();
            check("stall_tvalid", 32'(bus.fifo_in_tvalid), 1);
            check("stall_x_hold", 32'(bus.X_read_addr), 32'(xa0));
            check("stall_w_hold", 32'(bus.W_read_addr), 32'(wa0));
            check("stall_miv", 32'(bus.mac_input_valid), 0);
        end
        check("stall_no_write", writes, 0);
        bus.fifo_in_tready = 1'b1;
        tick();
        check("stall_one_write", writes, 1);
        check("stall_tvalid_drop", 32'(bus.fifo_in_tvalid), 0);
        wait_finish(2000, 1'b0, used);
        end_set(36);

        // K=1: every term is a window start.
        start_set(1);
        wait_finish(2000, 1'b0, used);
        end_set(64);

        // K=5 (MAXK): corner windows reach X addr 63 and W addr 24.
        start_set(5);
        wait_finish(2000, 1'b0, used);
        end_set(16);

        // K=2 with random backpressure.
        start_set(2);
        wait_finish(4000, 1'b1, used);
        bus.fifo_in_tready = 1'b1;
        end_set(49);

        // Unsupported kernel sizes finish without any MAC or FIFO activity.
        start_set(6);
        wait_finish(10, 1'b0, used);
        check("k6_latency", 32'(used <= 2), 1);
        end_set(0);
        start_set(0);
        wait_finish(10, 1'b0, used);
        check("k0_latency", 32'(used <= 2), 1);
        end_set(0);

        // Reset in the middle of ISSUE abandons the set.
        start_set(3);
        n = 0;
        while (bus.mac_input_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("issue_reached", 32'(bus.mac_input_valid), 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_x_addr", 32'(bus.X_read_addr), 0);
        check("mid_rst_w_addr", 32'(bus.W_read_addr), 0);
        check("mid_rst_miv", 32'(bus.mac_input_valid), 0);
        check("mid_rst_init", 32'(bus.mac_init_acc), 0);
        check("mid_rst_tvalid", 32'(bus.fifo_in_tvalid), 0);
        exp_terms.delete();
        bus.inputs_loaded = 1'b0;
        repeat (2) tick();
        prev_tvalid = 1'b0;
        prev_xa     = '0;
        prev_wa     = '0;
        reset       = 1'b1;
        repeat (5) begin
            tick();
            check("idle_miv", 32'(bus.mac_input_valid), 0);
            check("idle_tvalid", 32'(bus.fifo_in_tvalid), 0);
        end
        start_set(1);
        wait_finish(2000, 1'b0, used);
        end_set(64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
